apb_multi_timer: RTL and testbench

//  APB-slave timer, NUM_CH compare channels against one free-running CNT_W-bit counter.

---
 rtl/apb_multi_timer.sv | 254 +++++++++++++++++++++++++
 tb/tb_apb_multi_timer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_timer.sv
// ---------------------------------------------------------------------------
// apb_multi_timer
//   APB slave timer. One free-running CNT_W-bit counter is compared against
//   NUM_CH compare registers. It has an optional power-of-two prescaler,
//   per-channel write-1-to-clear interrupt status, a periodic mode that
//   reloads on compare channel 0, and a debug-halt handshake.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   psel, penable,      APB request (write commits on the clock edge that
//   pwrite, paddr,        ends the access phase); paddr[1:0] are ignored
//   pwdata, pstrb       write data and byte strobes (applied to all registers)
//   prdata              read data, driven only during a read access phase
//   pready              always 1 (zero wait states)
//   pslverr             error on an illegal TCR write, during the access phase
//   dbg_mode            CPU debug mode, gates the halt request
//   ch_int[NUM_CH]      per-channel interrupt, TISR & TIER
//   tim_int             OR of ch_int
//
// Register map (byte addresses)
//   0x000 TCR    [0] en  [1] div_en  [2] periodic  [11:8] div_val
//   0x004 TDR lo / 0x008 TDR hi     counter value
//   0x010+8n / 0x014+8n             TCMPn lo / hi
//   0x040 TIER   0x044 TISR (W1C)   0x048 THCSR [0] halt_req  [1] halt_ack
// ---------------------------------------------------------------------------
module apb_multi_timer #(
    parameter int CNT_W  = 64,
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [11:0]       paddr,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              dbg_mode,
    output logic [NUM_CH-1:0] ch_int,
    output logic              tim_int
);

    // Word addresses (paddr[11:2])
    localparam logic [9:0] A_TCR       = 10'h000;
    localparam logic [9:0] A_TDR_LO    = 10'h001;
    localparam logic [9:0] A_TDR_HI    = 10'h002;
    localparam logic [9:0] A_TCMP_BASE = 10'h004;
    localparam logic [9:0] A_TIER      = 10'h010;
    localparam logic [9:0] A_TISR      = 10'h011;
    localparam logic [9:0] A_THCSR     = 10'h012;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // State
    logic              en_q,       en_d;
    logic              div_en_q,   div_en_d;
    logic              periodic_q, periodic_d;
    logic [3:0]        div_val_q,  div_val_d;
    logic [7:0]        presc_q,    presc_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [CNT_W-1:0]  tcmp_q [NUM_CH];
    logic [CNT_W-1:0]  tcmp_d [NUM_CH];
    logic [NUM_CH-1:0] tier_q,     tier_d;
    logic [NUM_CH-1:0] tisr_q,     tisr_d;
    logic              halt_req_q, halt_req_d;
    logic              halt_ack_q, halt_ack_d;

    // Decode and helpers
    logic              wr_en, rd_en;
    logic [9:0]        word;
    logic [31:0]       tcr_rd, tcr_wr, tier_wr, rd_data;
    logic              tcr_err, tcr_wr_ok;
    logic [8:0]        presc_lim;
    logic              tick;
    logic [63:0]       cnt_ext;
    logic [63:0]       tcmp_ext [NUM_CH];
    logic [NUM_CH-1:0] match, tisr_clr;

    assign wr_en  = psel && penable && pwrite;
    assign rd_en  = psel && penable && !pwrite;
    assign word   = paddr[11:2];
    assign pready = 1'b1;

    // Zero-extended views so the word slicing is identical for CNT_W 32 and 64;
    // upper words simply read 0 and truncate away on write when CNT_W is 32.
    assign cnt_ext = 64'(cnt_q);
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            tcmp_ext[n] = 64'(tcmp_q[n]);
        end
    end

    // TCR: the byte-merged write value is what gets checked, so a write whose
    // strobes skip byte 1 cannot disturb div_val.
    assign tcr_rd    = {20'h0, div_val_q, 5'h0, periodic_q, div_en_q, en_q};
    assign tcr_wr    = strb_merge(tcr_rd, pwdata, pstrb);
    assign tcr_err   = (tcr_wr[11:8] > 4'd8) ||
                       (en_q && ((tcr_wr[1] != div_en_q) || (tcr_wr[11:8] != div_val_q)));
    assign tcr_wr_ok = wr_en && (word == A_TCR) && !tcr_err;
    assign pslverr   = wr_en && (word == A_TCR) && tcr_err;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        en_d       = en_q;
        div_en_d   = div_en_q;
        periodic_d = periodic_q;
        div_val_d  = div_val_q;
        if (tcr_wr_ok) begin
            en_d       = tcr_wr[0];
            div_en_d   = tcr_wr[1];
            periodic_d = tcr_wr[2];
            div_val_d  = tcr_wr[11:8];
        end
    end

    // Prescaler: terminal count 2^div_val-1 (div_val never exceeds 8).
    assign presc_lim = (9'd1 << div_val_q) - 9'd1;
    assign tick      = en_q && !halt_ack_q && (!div_en_q || (presc_q == presc_lim[7:0]));

    always_comb begin
        presc_d = presc_q;
        if (!en_q || !div_en_q) begin
            presc_d = '0;
        end else if (halt_ack_q) begin
            presc_d = presc_q;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 8'd1;
        end
    end

    // Counter: a software write wins over a tick in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && (word == A_TDR_LO)) begin
            cnt_d = CNT_W'({cnt_ext[63:32], strb_merge(cnt_ext[31:0], pwdata, pstrb)});
        end else if (wr_en && (word == A_TDR_HI)) begin
            cnt_d = CNT_W'({strb_merge(cnt_ext[63:32], pwdata, pstrb), cnt_ext[31:0]});
        end else if (tick) begin
            cnt_d = (periodic_q && (cnt_q == tcmp_q[0])) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Compare registers and level-sensitive match (fires while stopped too).
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            tcmp_d[n] = tcmp_q[n];
            if (wr_en && (word == A_TCMP_BASE + 10'(2*n))) begin
                tcmp_d[n] = CNT_W'({tcmp_ext[n][63:32],
                                    strb_merge(tcmp_ext[n][31:0], pwdata, pstrb)});
            end else if (wr_en && (word == A_TCMP_BASE + 10'(2*n + 1))) begin
                tcmp_d[n] = CNT_W'({strb_merge(tcmp_ext[n][63:32], pwdata, pstrb),
                                    tcmp_ext[n][31:0]});
            end
            match[n] = (cnt_q == tcmp_q[n]);
        end
    end

    // Interrupt enable/status. A match in the clearing cycle keeps the bit set.
    assign tier_wr  = strb_merge(32'(tier_q), pwdata, pstrb);
    assign tisr_clr = (wr_en && (word == A_TISR) && pstrb[0]) ? pwdata[NUM_CH-1:0] : '0;

    always_comb begin
        tier_d = tier_q;
        if (wr_en && (word == A_TIER)) begin
            tier_d = tier_wr[NUM_CH-1:0];
        end
        tisr_d = (tisr_q & ~tisr_clr) | match;
    end

    // Debug halt: ack only while the CPU is actually in debug mode.
    always_comb begin
        halt_req_d = halt_req_q;
        if (wr_en && (word == A_THCSR) && pstrb[0]) begin
            halt_req_d = pwdata[0];
        end
        halt_ack_d = halt_req_q && dbg_mode;
    end

    // Read mux
    always_comb begin
        rd_data = '0;
        case (word)
            A_TCR:    rd_data = tcr_rd;
            A_TDR_LO: rd_data = cnt_ext[31:0];
            A_TDR_HI: rd_data = cnt_ext[63:32];
            A_TIER:   rd_data = 32'(tier_q);
            A_TISR:   rd_data = 32'(tisr_q);
            A_THCSR:  rd_data = {30'h0, halt_ack_q, halt_req_q};
            default:  rd_data = '0;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
            if (word == A_TCMP_BASE + 10'(2*n))     rd_data = tcmp_ext[n][31:0];
            if (word == A_TCMP_BASE + 10'(2*n + 1)) rd_data = tcmp_ext[n][63:32];
        end
    end

    assign prdata  = rd_en ? rd_data : '0;
    assign ch_int  = tisr_q & tier_q;
    assign tim_int = |ch_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            div_en_q   <= 1'b0;
            periodic_q <= 1'b0;
            div_val_q  <= 4'd1;
            presc_q    <= '0;
            cnt_q      <= '0;
            // NOTE: the compare array is a handful of flops with a defined reset value, so it is reset like any other register rather than left as uninitialised storage.
            for (int n = 0; n < NUM_CH; n++) begin
                tcmp_q[n] <= '1;
            end
            tier_q     <= '0;
            tisr_q     <= '0;
            halt_req_q <= 1'b0;
            halt_ack_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
            en_q       <= en_d;
            div_en_q   <= div_en_d;
            periodic_q <= periodic_d;
            div_val_q  <= div_val_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            for (int n = 0; n < NUM_CH; n++) begin
                tcmp_q[n] <= tcmp_d[n];
            end
            tier_q     <= tier_d;
            tisr_q     <= tisr_d;
            halt_req_q <= halt_req_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    // Bits that are intentionally not consumed.
    logic unused_bits;
    assign unused_bits = &{1'b0, paddr[1:0], tcr_wr[31:12], tcr_wr[7:3],
                           presc_lim[8], tier_wr[31:NUM_CH]};

endmodule

// File: tb/tb_apb_multi_timer.sv
// ---------------------------------------------------------------------------
// tb_apb_multi_timer
//   Self-checking bench for apb_multi_timer (CNT_W=64, NUM_CH=4).
//   Register reads go through a small scoreboard queue: the expected value is
//   pushed when the read is launched and popped when prdata is sampled.
// ---------------------------------------------------------------------------
module tb_apb_multi_timer;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        dbg_mode;
    logic [3:0]  ch_int;
    logic        tim_int;

    apb_multi_timer #(.CNT_W(64), .NUM_CH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .dbg_mode(dbg_mode),
        .ch_int  (ch_int),
        .tim_int (tim_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] exp;
        string       name;
    } reg_vec_t;

    // tcr: enable value; d: cycles between enable and disable commits;
    // exp: counter value after the run.
    typedef struct {
        logic [31:0] tcr;
        int          d;
        logic [31:0] exp;
        string       name;
    } presc_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Setup on one edge, access on the next, commit on the third.
    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'hF;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic err;
        apb_write(addr, data, 4'hF, err);
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        data = prdata;
        err  = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_expect(input logic [11:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] data;
        logic        err;
        sb_entry_t   e;
        sb_q.push_back('{name: name, exp: exp});
        apb_read(addr, data, err);
        e = sb_q.pop_front();
        check(e.name, data, e.exp);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_vec_t    reset_tbl [15];
        presc_vec_t  presc_tbl [7];
        logic        err;
        logic [31:0] data;
        int          waited;

        reset_tbl = '{
            '{12'h000, 32'h0000_0100, "rst_TCR"},
            '{12'h004, 32'h0000_0000, "rst_TDR_lo"},
            '{12'h008, 32'h0000_0000, "rst_TDR_hi"},
            '{12'h010, 32'hFFFF_FFFF, "rst_TCMP0_lo"},
            '{12'h014, 32'hFFFF_FFFF, "rst_TCMP0_hi"},
            '{12'h018, 32'hFFFF_FFFF, "rst_TCMP1_lo"},
            '{12'h01C, 32'hFFFF_FFFF, "rst_TCMP1_hi"},
            '{12'h020, 32'hFFFF_FFFF, "rst_TCMP2_lo"},
            '{12'h024, 32'hFFFF_FFFF, "rst_TCMP2_hi"},
            '{12'h028, 32'hFFFF_FFFF, "rst_TCMP3_lo"},
            '{12'h02C, 32'hFFFF_FFFF, "rst_TCMP3_hi"},
            '{12'h040, 32'h0000_0000, "rst_TIER"},
            '{12'h044, 32'h0000_0000, "rst_TISR"},
            '{12'h048, 32'h0000_0000, "rst_THCSR"},
            '{12'h04C, 32'h0000_0000, "rst_unmapped"}
        };

        // Ticks within d cycles: floor(d / 2^div_val) when divided, d otherwise.
        presc_tbl = '{
            '{32'h0000_0001,  10, 32'd10, "nodiv_d10"},
            '{32'h0000_0003,  10, 32'd10, "div0_d10"},
            '{32'h0000_0203,  40, 32'd10, "div2_d40"},
            '{32'h0000_0303,   7, 32'd0,  "div3_d7"},
            '{32'h0000_0303,   8, 32'd1,  "div3_d8"},
            '{32'h0000_0303,  17, 32'd2,  "div3_d17"},
            '{32'h0000_0803, 259, 32'd1,  "div8_d259"}
        };

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = 4'hF; dbg_mode = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_prdata",  prdata,         32'h0);
        check("rst_pslverr", 32'(pslverr),   32'h0);
        check("rst_pready",  32'(pready),    32'h1);
        check("rst_tim_int", 32'(tim_int),   32'h0);
        check("rst_ch_int",  32'(ch_int),    32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            rd_expect(reset_tbl[i].addr, reset_tbl[i].exp, reset_tbl[i].name);
        end
        apb_read(12'h000, data, err);
        check("rst_read_pslverr", 32'(err), 32'h0);

        // ---------------- prescaler table ----------------
        // Enable commits at edge E0, disable commits at E0 + d.
        for (int i = 0; i < 7; i++) begin
            wr(12'h004, 32'h0);
            wr(12'h000, presc_tbl[i].tcr);
            repeat (presc_tbl[i].d - 3) @(posedge clk);
            apb_write(12'h000, presc_tbl[i].tcr & ~32'h1, 4'hF, err);
            check({presc_tbl[i].name, "_stop_err"}, 32'(err), 32'h0);
            rd_expect(12'h004, presc_tbl[i].exp, presc_tbl[i].name);
        end
        rd_expect(12'h008, 32'h0, "presc_TDR_hi");

        // ---------------- periodic mode and interrupt ----------------
        wr(12'h004, 32'h0);
        wr(12'h010, 32'd5);
        wr(12'h014, 32'h0);
        wr(12'h040, 32'h1);
        wr(12'h044, 32'hF);
        wr(12'h000, 32'h0000_0005);   // en, periodic, no divider
        // Counter hits 5 after E0+5; TISR sets at E0+6, seen on the 7th negedge.
        waited = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tim_int) begin
                waited = i;
                break;
            end
        end
        check("periodic_irq_latency", 32'(waited), 32'd7);
        wr(12'h000, 32'h0000_0004);   // stop at E0+9: 0..5,0,1,2,3
        rd_expect(12'h004, 32'd3, "periodic_wrap_cnt");
        check("periodic_tim_int_held", 32'(tim_int), 32'h1);
        check("periodic_ch_int", 32'(ch_int), 32'h1);
        rd_expect(12'h044, 32'h1, "periodic_TISR_set");
        wr(12'h044, 32'h1);
        @(negedge clk);
        check("tisr_w1c_tim_int", 32'(tim_int), 32'h0);
        rd_expect(12'h044, 32'h0, "tisr_w1c_cleared");

        // Match while stopped, clear during match: set wins.
        wr(12'h004, 32'd5);
        rd_expect(12'h044, 32'h1, "stopped_match_sets");
        wr(12'h044, 32'h1);
        rd_expect(12'h044, 32'h1, "set_beats_clear");
        wr(12'h040, 32'h0);
        @(negedge clk);
        check("tier_masks_ch_int", 32'(ch_int), 32'h0);
        wr(12'h004, 32'h0);
        wr(12'h044, 32'hF);
        rd_expect(12'h044, 32'h0, "tisr_clear_after_move");

        // ---------------- 64-bit wrap ----------------
        wr(12'h004, 32'hFFFF_FFFF);
        rd_expect(12'h044, 32'h0, "wrap_no_match_half");
        wr(12'h008, 32'hFFFF_FFFF);
        wr(12'h000, 32'h0000_0203);   // div by 4: one tick in 5 cycles
        repeat (2) @(posedge clk);
        wr(12'h000, 32'h0000_0202);
        rd_expect(12'h004, 32'h0, "wrap_lo");
        rd_expect(12'h008, 32'h0, "wrap_hi");
        rd_expect(12'h044, 32'hE, "wrap_allones_match");
        wr(12'h044, 32'hF);

        // ---------------- pslverr ----------------
        apb_write(12'h000, 32'h0000_0203, 4'hF, err);
        check("err_enable_ok", 32'(err), 32'h0);
        apb_write(12'h000, 32'h0000_0303, 4'hF, err);
        check("err_div_change_running", 32'(err), 32'h1);
        rd_expect(12'h000, 32'h0000_0203, "err_tcr_unchanged");
        apb_write(12'h000, 32'h0000_0202, 4'hF, err);
        check("err_disable_ok", 32'(err), 32'h0);
        apb_write(12'h000, 32'h0000_0900, 4'hF, err);
        check("err_div_val_9", 32'(err), 32'h1);
        rd_expect(12'h000, 32'h0000_0202, "err_tcr_unchanged2");
        apb_write(12'h04C, 32'hDEAD_BEEF, 4'hF, err);
        check("err_unmapped_write", 32'(err), 32'h0);
        apb_write(12'h010, 32'hAABB_CCDD, 4'b0101, err);
        rd_expect(12'h010, 32'h00BB_00DD, "strobe_merge_tcmp0");
        wr(12'h02C, 32'h1234_5678);
        rd_expect(12'h02C, 32'h1234_5678, "tcmp3_hi_rw");

        // ---------------- debug halt ----------------
        wr(12'h004, 32'h0);
        dbg_mode = 1'b1;
        wr(12'h000, 32'h0000_0001);   // E0
        wr(12'h048, 32'h1);           // halt_req at E0+3, ack at E0+4
        rd_expect(12'h048, 32'h3, "halt_ack_set");
        rd_expect(12'h004, 32'd4, "halt_frozen_a");
        repeat (20) @(posedge clk);
        rd_expect(12'h004, 32'd4, "halt_frozen_b");
        dbg_mode = 1'b0;              // ack drops next edge, one tick before sample
        rd_expect(12'h004, 32'd5, "halt_release_resume");
        rd_expect(12'h048, 32'h1, "halt_ack_clear");

        // ---------------- async reset mid-operation ----------------
        wr(12'h000, 32'h0);
        wr(12'h040, 32'hF);
        wr(12'h004, 32'h00BB_00DD);   // equals TCMP0
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_tim_int", 32'(tim_int), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tim_int", 32'(tim_int), 32'h0);
        check("async_rst_ch_int",  32'(ch_int),  32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd_expect(12'h000, 32'h0000_0100, "post_rst_TCR");
        rd_expect(12'h004, 32'h0,         "post_rst_TDR_lo");
        rd_expect(12'h010, 32'hFFFF_FFFF, "post_rst_TCMP0_lo");
        rd_expect(12'h040, 32'h0,         "post_rst_TIER");
        rd_expect(12'h044, 32'h0,         "post_rst_TISR");
        rd_expect(12'h048, 32'h0,         "post_rst_THCSR");
        check("post_rst_tim_int", 32'(tim_int), 32'h0);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
